// File: rtl/apb_pkg.sv
// Shared types for the APB requester-side arbiter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first valid requester after ptr,
// wrapping around. Returns both one-hot and index forms.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic             found;
  int               idx;
  logic [IDX_W-1:0] idx_v;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    idx_v    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(ptr) + i) % NUM_REQ;
      idx_v = idx[IDX_W-1:0];
      if (!found && req_valid[idx_v]) begin
        found        = 1'b1;
        pick[idx_v]  = 1'b1;
        pick_idx     = idx_v;
      end
    end
  end

endmodule

// File: rtl/apb_mrsc_arbiter.sv
// APB requester-side arbiter: NUM_REQ local requesters share one APB completer
// round-robin; a completer stalling longer than TIMEOUT_CYCLES is aborted.
//
// state  | meaning
// IDLE   | bus idle, waiting for any req_valid
// SETUP  | PSEL=1 PENABLE=0 for one cycle, grant pulse to the winner
// ACCESS | PSEL=1 PENABLE=1 until PREADY or timeout
module apb_mrsc_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [NUM_REQ-1:0] owner, owner_nxt;
  logic [CNT_W-1:0]  wait_cnt, cnt_nxt;

  logic                  psel_nxt, penable_nxt, pwrite_nxt, err_nxt, start;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt, rdata_nxt;
  logic [NUM_REQ-1:0]    grant_nxt, done_nxt;

  logic [NUM_REQ-1:0]    pick;
  logic [IDX_W-1:0]      pick_idx;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .ptr       (ptr),
    .pick      (pick),
    .pick_idx  (pick_idx)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    cnt_nxt     = wait_cnt;
    psel_nxt    = PSEL;
    penable_nxt = PENABLE;
    pwrite_nxt  = PWRITE;
    paddr_nxt   = PADDR;
    pwdata_nxt  = PWDATA;
    grant_nxt   = '0;
    done_nxt    = '0;
    rdata_nxt   = rsp_rdata;
    err_nxt     = rsp_err;
    start       = 1'b0;

    case (state)
      IDLE: start = |req_valid;
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          done_nxt = owner;
          err_nxt  = PSLVERR;
          if (!PWRITE) rdata_nxt = PRDATA;
          if (|req_valid) begin
            start = 1'b1;
          end else begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
          end
        end else if (wait_cnt == CNT_LAST) begin
          // this would be the TIMEOUT_CYCLES-th stalled cycle: abort
          done_nxt    = owner;
          err_nxt     = 1'b1;
          rdata_nxt   = '0;
          state_nxt   = IDLE;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase

    if (start) begin
      state_nxt   = SETUP;
      psel_nxt    = 1'b1;
      penable_nxt = 1'b0;
      pwrite_nxt  = sel_write;
      paddr_nxt   = sel_addr;
      pwdata_nxt  = sel_write ? sel_wdata : '0;
      grant_nxt   = pick;
      ptr_nxt     = pick_idx;
      owner_nxt   = pick;
      cnt_nxt     = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      req_grant <= '0;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      wait_cnt  <= cnt_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      req_grant <= grant_nxt;
      req_done  <= done_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_mrsc_arbiter.sv
// Bench for apb_mrsc_arbiter: requester and completer models feed queues, a
// monitor checks grants, APB phases and responses against a round-robin model.
module tb_apb_mrsc_arbiter;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int TO = 16;

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } req_t;
  typedef struct { int idx; logic w; logic [AW-1:0] a; logic [DW-1:0] d; int gcyc; } xfer_t;
  typedef struct { logic to; logic err; logic [DW-1:0] rd; int len; } cpl_t;

  logic PCLK = 1'b0;
  logic PRESETN;
  logic [NR-1:0]    req_valid, req_write, req_grant, req_done;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, PWDATA, PRDATA;
  logic             rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]    PADDR;

  apb_mrsc_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0, bad = 0;
  int cyc = 0, n_issue = 0, n_done = 0, last_done_cyc = 0;
  req_t  pend[NR][$];
  xfer_t xq[$];
  cpl_t  cq[$];

  int f_wt = 0;
  logic f_slverr = 1'b0;
  logic [DW-1:0] f_prdata = '0;
  bit f_rand = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (last + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic push_req(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    req_t r;
    r.w = w; r.a = a; r.d = d;
    pend[i].push_back(r);
    n_issue++;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (n_done != n_issue && k < budget) begin
      @(negedge PCLK);
      k++;
    end
    chk("drain", 64'(n_done), 64'(n_issue));
  endtask

  task automatic wait_grant(int budget, output int at_cyc);
    int k = 0;
    while (req_grant == '0 && k < budget) begin
      @(negedge PCLK);
      k++;
    end
    at_cyc = cyc;
    if (req_grant == '0) chk("grant_wait", 64'(req_grant), 64'd1);
  endtask

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  // requester models: present queued requests, drop valid once granted
  initial begin
    req_t r;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(posedge PCLK); #1;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_grant[i]) begin
          req_valid[i] = 1'b0;
          req_addr[i*AW +: AW] = AW'($urandom);
        end else if (!req_valid[i] && pend[i].size() > 0) begin
          r = pend[i].pop_front();
          req_valid[i] = 1'b1;
          req_write[i] = r.w;
          req_addr[i*AW +: AW] = r.a;
          req_wdata[i*DW +: DW] = r.d;
        end
      end
    end
  end

  // completer model: decides the wait and response at SETUP, records the expectation
  initial begin
    int c_wt, c_cnt, r;
    cpl_t c;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; c_wt = 0; c_cnt = 0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESETN) begin
        PREADY = 1'b0;
      end else if (PSEL && !PENABLE) begin
        if (f_rand) begin
          r = int'($urandom_range(0, 19));
          c_wt = (r < 14) ? r % 4 : ((r < 17) ? TO - 1 : TO);
          PSLVERR = ($urandom_range(0, 3) == 0);
          PRDATA = DW'($urandom);
        end else begin
          c_wt = f_wt; PSLVERR = f_slverr; PRDATA = f_prdata;
        end
        c_cnt = 0;
        PREADY = 1'b0;
        c.to = (c_wt >= TO);
        c.err = PSLVERR;
        c.rd = PRDATA;
        c.len = c.to ? TO : c_wt + 1;
        cq.push_back(c);
      end else if (PSEL && PENABLE) begin
        c_cnt++;
        PREADY = (c_cnt > c_wt);
      end else begin
        PREADY = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [NR-1:0] prev_valid = '0, prev_write = '0;
    logic [NR*AW-1:0] prev_addr = '0;
    logic [NR*DW-1:0] prev_wdata = '0;
    logic prev_psel = 1'b0, prev_rst = 1'b0;
    logic [DW-1:0] last_rdata = '0;
    int last_w = NR - 1;
    int e;
    xfer_t x;
    cpl_t c;
    forever begin
      @(negedge PCLK);
      if (!PRESETN) begin
        chk("reset_outputs", 64'({req_grant, req_done, rsp_rdata, rsp_err, PSEL, PENABLE,
                                 PWRITE, PADDR, PWDATA}), 64'd0);
        xq.delete(); cq.delete();
        last_w = NR - 1;
        last_rdata = '0;
      end else begin
        if (req_done != '0) begin
          if (xq.size() == 0 || cq.size() == 0) begin
            chk("done_unexpected", 64'(req_done), 64'd0);
          end else begin
            x = xq.pop_front();
            c = cq.pop_front();
            last_rdata = c.to ? '0 : (x.w ? last_rdata : c.rd);
            chk("done_owner", 64'(req_done), 64'd1 << x.idx);
            chk("rsp_err", 64'(rsp_err), 64'(c.to ? 1'b1 : c.err));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(last_rdata));
            chk("done_latency", 64'(cyc - x.gcyc), 64'(c.len + 1));
            chk("psel_after_done", 64'(PSEL), 64'(!c.to && prev_valid != '0));
            n_done++;
            last_done_cyc = cyc;
          end
        end
        if (prev_rst && !prev_psel && prev_valid != '0)
          chk("idle_arbitrate", 64'(PSEL), 64'd1);
        if (PSEL && !PENABLE)
          chk("setup_has_grant", 64'(req_grant != '0), 64'd1);
        if (req_grant != '0) begin
          e = rr_pick(prev_valid, last_w);
          chk("grant", 64'(req_grant), (e < 0) ? 64'd0 : (64'd1 << e));
          chk("setup_phase", 64'({PSEL, PENABLE}), 64'b10);
          if (e >= 0) begin
            last_w = e;
            x.idx = e;
            x.w = prev_write[e];
            x.a = prev_addr[e*AW +: AW];
            x.d = x.w ? prev_wdata[e*DW +: DW] : '0;
            x.gcyc = cyc;
            xq.push_back(x);
            chk("setup_fields", 64'({PWRITE, PADDR, PWDATA}), 64'({x.w, x.a, x.d}));
          end
        end
        if (PSEL && PENABLE && xq.size() > 0)
          chk("access_fields", 64'({PWRITE, PADDR, PWDATA}), 64'({xq[0].w, xq[0].a, xq[0].d}));
      end
      prev_valid = req_valid;
      prev_write = req_write;
      prev_addr  = req_addr;
      prev_wdata = req_wdata;
      prev_psel  = PSEL;
      prev_rst   = PRESETN;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int t0, k;
    PRESETN = 1'b0;
    repeat (3) @(posedge PCLK);
    #2 PRESETN = 1'b1;

    // single write, completer always ready
    f_rand = 0; f_wt = 0; f_slverr = 0; f_prdata = 16'h0;
    push_req(0, 1'b1, 10'h001, 16'hBB22);
    wait_idle(40);
    chk("t1_err", 64'(rsp_err), 64'd0);
    chk("t1_idle_paddr", 64'({PSEL, PENABLE, PADDR, PWDATA}), 64'({2'b00, 10'h001, 16'hBB22}));

    // read with two wait states
    f_wt = 2; f_prdata = 16'hBB44;
    push_req(1, 1'b0, 10'h003, 16'hFFFF);
    wait_idle(40);
    chk("t2_rdata", 64'(rsp_rdata), 64'hBB44);
    chk("t2_idle_pwdata", 64'({PADDR, PWDATA}), 64'({10'h003, 16'h0000}));

    // both requesters busy: back-to-back alternating transfers
    f_wt = 0; f_prdata = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1'(i % 2), AW'(10 + i), DW'(16'h1000 + i));
      push_req(1, 1'((i + 1) % 2), AW'(20 + i), DW'(16'h2000 + i));
    end
    wait_grant(20, t0);
    wait_idle(80);
    chk("t3_span", 64'(last_done_cyc - t0), 64'd16);

    // completer never ready: timeout
    f_wt = 1000; f_prdata = 16'hDEAD;
    push_req(0, 1'b0, 10'h0AA, 16'h0);
    wait_idle(60);
    chk("t4_err", 64'(rsp_err), 64'd1);
    chk("t4_rdata", 64'(rsp_rdata), 64'd0);

    // slave error on a read still returns data
    f_wt = 0; f_slverr = 1; f_prdata = 16'h1234;
    push_req(1, 1'b0, 10'h002, 16'h0);
    wait_idle(40);
    chk("t5_err", 64'(rsp_err), 64'd1);
    chk("t5_rdata", 64'(rsp_rdata), 64'h1234);

    // reset during ACCESS, then a 0/1 tie
    f_slverr = 0; f_wt = 1000;
    push_req(1, 1'b0, 10'h155, 16'h0);
    k = 0;
    while (!(PSEL && PENABLE) && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    chk("t6_in_access", 64'({PSEL, PENABLE}), 64'b11);
    @(posedge PCLK); #3;
    PRESETN = 1'b0;
    #1;
    chk("t6_async_drop", 64'({PSEL, PENABLE, req_done}), 64'd0);
    n_issue--;
    f_wt = 0;
    push_req(0, 1'b1, 10'h3C0, 16'hCAFE);
    push_req(1, 1'b1, 10'h3C1, 16'hBEEF);
    repeat (3) @(posedge PCLK);
    #2 PRESETN = 1'b1;
    @(negedge PCLK);
    wait_grant(10, t0);
    chk("t6_tie", 64'(req_grant), 64'b01);
    wait_idle(40);

    // randomized traffic and completer behaviour
    f_rand = 1;
    for (int i = 0; i < 150; i++) begin
      push_req(int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
               AW'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(posedge PCLK);
    end
    wait_idle(8000);
    repeat (3) @(posedge PCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
